mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand, HI and LO width; legal values are even and at least 8.
REQ-002 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-005 SHALL have port op, input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have ports a and b, input, WIDTH bits each: a is multiplicand or dividend; b is multiplier or divisor.
REQ-007 SHALL have ports wr_hi and wr_lo, input, 1 bit each: MTHI and MTLO write enables.
REQ-008 SHALL have port wdata, input, WIDTH bits: MTHI/MTLO data.
REQ-009 SHALL have port busy, output, 1 bit: high when the state is not IDLE.
REQ-010 SHALL have port done, output, 1 bit: registered one-cycle completion pulse.
REQ-011 SHALL have port dz, output, 1 bit: divide-by-zero flag, valid only while done=1.
REQ-012 SHALL have ports hi and lo, output, WIDTH bits each: architectural HI and LO registers.

Function
REQ-013 SHALL use the states IDLE, CALC and FIX: IDLE goes to CALC on start=1; CALC goes to FIX after exactly WIDTH iterations; FIX goes to IDLE.
REQ-014 SHALL latch op, a and b at the accepting edge, so later changes on those inputs have no effect on the running operation.
REQ-015 SHALL compute with magnitudes for signed operations: take operand magnitudes, iterate on them, then apply sign correction in FIX.
REQ-016 SHALL perform one shift-add step per CALC cycle for multiplication; the full 2*WIDTH-bit product goes HI = upper half, LO = lower half.
REQ-017 SHALL perform one restoring step per CALC cycle for division, giving LO = quotient and HI = remainder.
REQ-018 SHALL truncate signed quotients toward zero; the remainder takes the sign of the dividend.
REQ-019 SHALL meet this latency: with the start edge ending cycle 0, busy=1 in cycles 1..WIDTH+1, and HI/LO updated with done=1 in cycle WIDTH+2.
REQ-020 SHALL ignore start while busy=1.
REQ-021 SHALL ignore wr_hi and wr_lo while busy=1.
REQ-022 SHALL give start priority over a same-cycle write in IDLE: the write is dropped.
REQ-023 SHALL, when wr_hi and wr_lo are asserted together in IDLE, write wdata to both HI and LO on the next edge.
REQ-024 SHALL handle a divisor of 0 as follows: full latency still applies, LO = all ones, HI = a, dz=1 with done.
REQ-025 SHALL handle signed DIV of the most negative value by -1 as follows: LO = most negative value, HI = 0, dz=0.
REQ-026 SHALL leave HI and LO unchanged except by a FIX completion or an accepted MTHI/MTLO write.
REQ-027 SHALL hold dz at 0 whenever done=0.

Reset
REQ-028 SHALL, on rst=1, go to IDLE immediately and set hi=0, lo=0, busy=0, done=0, dz=0, and clear the iteration counter.
REQ-029 SHALL, when rst is asserted mid-operation, abort the operation with no done pulse and no HI/LO update.
REQ-030 SHALL accept a new start on the first rising edge after rst deasserts.

Configuration
REQ-031 SHALL compile the divider datapath in only when macro MUL_DIV_UNIT_DIV_EN is defined.
REQ-032 SHALL, without MUL_DIV_UNIT_DIV_EN, treat start with op[1]=1 as a no-op: no busy, no done, HI/LO unchanged, dz held at 0.
REQ-033 SHALL leave the multiply behaviour and timing identical with or without MUL_DIV_UNIT_DIV_EN.

Verification (WIDTH=32, MUL_DIV_UNIT_DIV_EN defined unless stated)
REQ-034 SHALL cover MULT a=0xFFFFFFFD, b=7 -> busy cycles 1..33; in cycle 34 done=1, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-035 SHALL cover MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-036 SHALL cover DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF, dz=0; also DIV 0x80000000 by 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-037 SHALL cover DIVU a=5, b=0 -> in cycle 34 done=1, dz=1, LO=0xFFFFFFFF, HI=0x00000005.
REQ-038 SHALL cover MTHI wdata=0x1234 in IDLE, then a second start plus wr_lo during a busy MULTU -> HI=0x1234 after the write, the extra start and the wr_lo are ignored, and the result matches the first operation only.
REQ-039 SHALL cover rst asserted in cycle 10 of a DIVU -> busy=0, HI=LO=0 at once, no done pulse; with the macro undefined, DIV start -> busy stays 0.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: one shift-add or restoring step per cycle.
// Divider datapath is present only when MUL_DIV_UNIT_DIV_EN is defined.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam int unsigned PW   = 2 * WIDTH;

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e state_q, state_d;

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic             op_ok;
  logic             accept;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH:0]   sum;
  logic [PW-1:0]    prod;

`ifdef MUL_DIV_UNIT_DIV_EN
  logic             is_div_q, is_div_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  assign op_ok = 1'b1;
`else
  // Division requests are silently dropped when the divider is not built.
  assign op_ok = ~op[1];
`endif

  assign accept = (state_q == StIdle) && start && op_ok;
  assign a_neg  = ~op[0] & a[WIDTH-1];
  assign b_neg  = ~op[0] & b[WIDTH-1];

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StCalc;
      StCalc:  if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q != StIdle);
  end

  // Datapath next-state
  always_comb begin
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dz_d     = 1'b0;
    sum      = '0;
    prod     = '0;
`ifdef MUL_DIV_UNIT_DIV_EN
    is_div_d = is_div_q;
    shifted  = '0;
    diff     = '0;
    ge       = 1'b0;
    quo      = '0;
    rem      = '0;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (accept) begin
            cnt_d    = '0;
            acc_hi_d = '0;
            neg_a_d  = a_neg;
            neg_b_d  = b_neg;
`ifdef MUL_DIV_UNIT_DIV_EN
            is_div_d = op[1];
            if (op[1]) begin
              acc_lo_d = mag(a, a_neg);
              opnd_d   = mag(b, b_neg);
            end else begin
              acc_lo_d = mag(b, b_neg);
              opnd_d   = mag(a, a_neg);
            end
`else
            acc_lo_d = mag(b, b_neg);
            opnd_d   = mag(a, a_neg);
`endif
          end
        end else begin
          if (wr_hi) hi_d = wdata;
          if (wr_lo) lo_d = wdata;
        end
      end

      StCalc: begin
        cnt_d = cnt_q + CntW'(1);
`ifdef MUL_DIV_UNIT_DIV_EN
        if (is_div_q) begin
          shifted  = {acc_hi_q, acc_lo_q[WIDTH-1]};
          diff     = shifted - {1'b0, opnd_q};
          ge       = (shifted >= {1'b0, opnd_q});
          acc_hi_d = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], ge};
        end else begin
          sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
          {acc_hi_d, acc_lo_d} = {sum, acc_lo_q[WIDTH-1:1]};
        end
`else
        sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        {acc_hi_d, acc_lo_d} = {sum, acc_lo_q[WIDTH-1:1]};
`endif
      end

      StFix: begin
        done_d = 1'b1;
`ifdef MUL_DIV_UNIT_DIV_EN
        if (is_div_q) begin
          quo = (neg_a_q ^ neg_b_q) ? (~acc_lo_q + WIDTH'(1)) : acc_lo_q;
          rem = neg_a_q ? (~acc_hi_q + WIDTH'(1)) : acc_hi_q;
          // With a zero divisor the remainder path already reconstructs a.
          lo_d = (opnd_q == '0) ? '1 : quo;
          hi_d = rem;
          dz_d = (opnd_q == '0);
        end else begin
          prod = {acc_hi_q, acc_lo_q};
          if (neg_a_q ^ neg_b_q) prod = ~prod + PW'(1);
          {hi_d, lo_d} = prod;
        end
`else
        prod = {acc_hi_q, acc_lo_q};
        if (neg_a_q ^ neg_b_q) prod = ~prod + PW'(1);
        {hi_d, lo_d} = prod;
`endif
      end

      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
`ifdef MUL_DIV_UNIT_DIV_EN
      is_div_q <= 1'b0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
`ifdef MUL_DIV_UNIT_DIV_EN
      is_div_q <= is_div_d;
`endif
    end
  end

  assign done = done_q;
  assign dz   = dz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit (WIDTH=32); division vectors apply when
// MUL_DIV_UNIT_DIV_EN is defined, otherwise the division no-op behaviour is checked.
module tb_mul_div_unit;

  localparam int W = 32;

  logic          clk;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          wr_hi;
  logic          wr_lo;
  logic [W-1:0]  wdata;
  logic          busy;
  logic          done;
  logic          dz;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int n_chk;
  int n_fail;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .wr_hi (wr_hi),
    .wr_lo (wr_lo),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .dz    (dz),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  vec_t vecs[13];
  int   nvec;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Called just after a negedge; returns at the negedge of the done cycle.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                        output int dcyc, output int bad, output logic [W-1:0] rh,
                        output logic [W-1:0] rl, output logic rdz);
    dcyc = -1; bad = 0; rh = '0; rl = '0; rdz = 1'b0;
    op = o; a = va; b = vb; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~va; b = ~vb; op = ~o;
    for (int c = 1; c <= 60; c++) begin
      if (busy !== (c <= W + 1)) bad++;
      if (!done && dz) bad++;
      if (done) begin
        dcyc = c; rh = hi; rl = lo; rdz = dz;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input int c0, output int dcyc);
    dcyc = -1;
    for (int c = c0; c <= c0 + 60; c++) begin
      if (done) begin
        dcyc = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int           dcyc, bad;
    logic [W-1:0] rh, rl, prev_hi, prev_lo;
    logic         rdz;
    int           seen;

    n_chk = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;

    nvec = 0;
    vecs[nvec++] = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[nvec++] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[nvec++] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[nvec++] = '{2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
    vecs[nvec++] = '{2'b00, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 32'h80000000, 1'b0};
    vecs[nvec++] = '{2'b00, 32'h00000005, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF6, 1'b0};
`ifdef MUL_DIV_UNIT_DIV_EN
    vecs[nvec++] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[nvec++] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[nvec++] = '{2'b11, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
    vecs[nvec++] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[nvec++] = '{2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
    vecs[nvec++] = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[nvec++] = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
`endif

    repeat (2) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset dz", dz, 0);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < nvec; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, dcyc, bad, rh, rl, rdz);
      check($sformatf("vec%0d done cycle", i), dcyc, 34);
      check($sformatf("vec%0d busy/dz profile errors", i), bad, 0);
      check($sformatf("vec%0d hi", i), rh, vecs[i].hi);
      check($sformatf("vec%0d lo", i), rl, vecs[i].lo);
      check($sformatf("vec%0d dz", i), rdz, vecs[i].dz);
    end

    // MTHI in IDLE, then a stray start and wr_lo during a busy MULTU
    @(negedge clk);
    prev_lo = lo;
    wr_hi = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    wr_hi = 1'b0;
    check("mthi hi", hi, 32'h1234);
    check("mthi lo kept", lo, prev_lo);
    op = 2'b01; a = 32'd3; b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'hFFFF; b = 32'hFFFF; wr_lo = 1'b1; wdata = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; wr_lo = 1'b0;
    check("busy write hi kept", hi, 32'h1234);
    check("busy write lo kept", lo, prev_lo);
    wait_done(6, dcyc);
    check("busy seq done cycle", dcyc, 34);
    check("busy seq hi", hi, 0);
    check("busy seq lo", lo, 15);
    @(negedge clk);
    check("busy seq idle after", busy, 0);
    check("busy seq no 2nd done", done, 0);

    // start wins over a same-cycle MTHI
    op = 2'b01; a = 32'd2; b = 32'd3; start = 1'b1; wr_hi = 1'b1; wdata = 32'h7777;
    @(negedge clk);
    start = 1'b0; wr_hi = 1'b0;
    check("start prio hi", hi, 0);
    check("start prio busy", busy, 1);
    wait_done(1, dcyc);
    check("start prio done cycle", dcyc, 34);
    check("start prio lo", lo, 6);
    @(negedge clk);

    wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hA5A5A5A5;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b0;
    check("dual write hi", hi, 32'hA5A5A5A5);
    check("dual write lo", lo, 32'hA5A5A5A5);

`ifndef MUL_DIV_UNIT_DIV_EN
    prev_hi = hi; prev_lo = lo;
    op = 2'b10; a = 32'd10; b = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("nodiv busy", busy, 0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy || done || dz) seen++;
      @(negedge clk);
    end
    check("nodiv busy/done/dz activity", seen, 0);
    check("nodiv hi", hi, prev_hi);
    check("nodiv lo", lo, prev_lo);
`endif

    // Asynchronous reset in cycle 10 of an operation
`ifdef MUL_DIV_UNIT_DIV_EN
    op = 2'b11; a = 32'd1000; b = 32'd3;
`else
    op = 2'b01; a = 32'd1000; b = 32'd3;
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre-reset busy", busy, 1);
    rst = 1'b1;
    #1;
    check("abort busy", busy, 0);
    check("abort hi", hi, 0);
    check("abort lo", lo, 0);
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) seen++;
    end
    rst = 1'b0;
    run_op(2'b01, 32'd6, 32'd7, dcyc, bad, rh, rl, rdz);
    check("abort no done", seen, 0);
    check("post-reset done cycle", dcyc, 34);
    check("post-reset busy profile", bad, 0);
    check("post-reset lo", rl, 42);
    check("post-reset hi", rh, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
